// File: rtl/symbol_display_scanner_pkg.sv
// Shared definitions for the symbol display scanner: game status codes,
// segment glyphs, the digit count and the frame snapshot record.
package symbol_display_scanner_pkg;

    typedef enum logic [1:0] {
        CHK_IDLE  = 2'b00,
        CHK_PASS  = 2'b01,
        CHK_FAIL  = 2'b10,
        CHK_BLANK = 2'b11
    } check_e;

    // Active-low glyphs in {g,f,e,d,c,b,a} order.
    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [4:0] AN_OFF  = 5'b11111;

    localparam int NUM_DIGITS = 5;

    typedef struct packed {
        logic [1:0] first;
        logic [1:0] second;
        logic [1:0] third;
        logic [1:0] fourth;
        logic [1:0] main;
        check_e     status;
    } frame_t;

    // Active-low one-hot enable for a digit index; out-of-range indices select nothing.
    function automatic logic [4:0] digit_enable(input logic [2:0] idx);
        logic [4:0] en;
        en = AN_OFF;
        if (idx < 3'(NUM_DIGITS))
            en[idx] = 1'b0;
        return en;
    endfunction

endpackage

// File: rtl/symbol_display_scanner_seg_decode.sv
// Combinational 2-bit symbol code to active-low seven-segment glyph decoder.
module symbol_seg_decode
    import symbol_display_scanner_pkg::*;
(
    input  logic [1:0] code,
    output logic [6:0] seg
);

    always_comb begin
        unique case (code)
            2'b00:   seg = GLYPH_0;
            2'b01:   seg = GLYPH_1;
            2'b10:   seg = GLYPH_2;
            default: seg = GLYPH_3;
        endcase
    end

endmodule

// File: rtl/symbol_display_scanner.sv
// Five-digit multiplexed seven-segment scanner with per-frame code snapshot,
// ghost blanking, fail blinking and a frame-done strobe.
module symbol_display_scanner
    import symbol_display_scanner_pkg::*;
#(
    parameter logic [15:0] REFRESH_DIV = 16'd50000,
    parameter logic [23:0] BLINK_DIV   = 24'd12500000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       game_enable,
    input  logic [1:0] first_display,
    input  logic [1:0] second_display,
    input  logic [1:0] third_display,
    input  logic [1:0] fourth_display,
    input  logic [1:0] main_display,
    input  logic [1:0] checklight,
    output logic [6:0] seg,
    output logic [4:0] an,
    output logic       frame_done
);

    logic [15:0] slot_cnt;
    logic [2:0]  digit_idx;
    logic [23:0] blink_cnt;
    logic        blink_phase;
    frame_t      snap;

    logic        slot_last;
    logic        frame_wrap;
    logic        blink_last;
    logic [1:0]  code_sel;
    logic [6:0]  glyph;
    logic [6:0]  seg_next;
    logic [4:0]  an_next;

    assign slot_last  = (slot_cnt == REFRESH_DIV - 16'd1);
    assign frame_wrap = slot_last && (digit_idx == 3'(NUM_DIGITS - 1));
    assign blink_last = (blink_cnt == BLINK_DIV - 24'd1);

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would let later statements see new state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            slot_cnt    <= '0;
            digit_idx   <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            snap        <= '0;
            frame_done  <= 1'b0;
            seg         <= SEG_OFF;
            an          <= AN_OFF;
        end else begin
            slot_cnt <= slot_last ? 16'd0 : slot_cnt + 16'd1;
            if (slot_last)
                digit_idx <= (digit_idx >= 3'(NUM_DIGITS - 1)) ? 3'd0 : digit_idx + 3'd1;

            blink_cnt <= blink_last ? 24'd0 : blink_cnt + 24'd1;
            if (blink_last)
                blink_phase <= ~blink_phase;

            // Whole-frame capture keeps one scan from mixing old and new codes.
            if (frame_wrap)
                snap <= '{first:  first_display,
                          second: second_display,
                          third:  third_display,
                          fourth: fourth_display,
                          main:   main_display,
                          status: check_e'(checklight)};

            frame_done <= frame_wrap;
            seg        <= seg_next;
            an         <= an_next;
        end
    end

    always_comb begin
        code_sel = 2'b00;
        unique case (digit_idx)
            3'd0:    code_sel = snap.first;
            3'd1:    code_sel = snap.second;
            3'd2:    code_sel = snap.third;
            3'd3:    code_sel = snap.fourth;
            3'd4:    code_sel = snap.main;
            default: code_sel = 2'b00;
        endcase
    end

    symbol_seg_decode u_decode (
        .code (code_sel),
        .seg  (glyph)
    );

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        seg_next = SEG_OFF;
        an_next  = AN_OFF;
        if (game_enable && snap.status != CHK_BLANK) begin
            seg_next = glyph;
            // Slot value 0 is the ghost-blanking gap between digits.
            if (slot_cnt != 16'd0 && !(snap.status == CHK_FAIL && blink_phase))
                an_next = digit_enable(digit_idx);
        end
    end

endmodule
